// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//
// Resolves conditional branches in EX and keeps a 2-bit saturating-counter
// branch history table (BHT) that supplies fetch-stage predictions. The
// PC-source decision, redirect request and illegal-opcode flag are
// registered, so they appear one cycle after the sampling edge. The cycle
// after a redirect holds a wrong-path instruction in EX, and nothing
// resolves in that cycle.
//
// Ports
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   if_pc            fetch PC used for the prediction lookup
//   if_pred_taken    combinational prediction (MSB of the indexed BHT entry)
//   ex_valid         EX slot holds a valid instruction
//   ex_branch        EX instruction is a branch
//   ex_opcode        branch condition select
//   ex_rd1, ex_rd15  operands (source register and R15)
//   ex_pc            PC of the EX instruction
//   ex_target        branch target
//   ex_pred_taken    prediction made at fetch and carried down the pipe
//   pcsrc            registered: the resolved branch was taken
//   redirect         registered: mispredict, so fetch restarts at redirect_pc
//   redirect_pc      registered: correct next PC
//   illegal_br       registered: branch with an undefined opcode
//   br_cnt, mis_cnt  saturating counts of resolved branches and mispredicts

module branch_resolve_unit #(
    parameter int DATA_W    = 16,
    parameter int PC_W      = 16,
    parameter int BHT_DEPTH = 16,
    parameter int PC_INC    = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PC_W-1:0]   if_pc,
    output logic              if_pred_taken,
    input  logic              ex_valid,
    input  logic              ex_branch,
    input  logic [3:0]        ex_opcode,
    input  logic [DATA_W-1:0] ex_rd1,
    input  logic [DATA_W-1:0] ex_rd15,
    input  logic [PC_W-1:0]   ex_pc,
    input  logic [PC_W-1:0]   ex_target,
    input  logic              ex_pred_taken,
    output logic              pcsrc,
    output logic              redirect,
    output logic [PC_W-1:0]   redirect_pc,
    output logic              illegal_br,
    output logic [CNT_W-1:0]  br_cnt,
    output logic [CNT_W-1:0]  mis_cnt
);

    localparam int IDX_W = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1;

    logic [1:0]       bht [BHT_DEPTH];
    logic             shadow;
    logic             taken;
    logic             illegal;
    logic             resolve;
    logic             mispredict;
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic [PC_W-1:0]  fallthrough;

    // The depth is a power of two, so the modulo is just the low PC bits.
    assign if_idx = IDX_W'(if_pc % PC_W'(BHT_DEPTH));
    assign ex_idx = IDX_W'(ex_pc % PC_W'(BHT_DEPTH));

    // No bypass: a same-cycle update to this entry is not visible here.
    assign if_pred_taken = bht[if_idx][1];

    // Branch condition evaluation; undefined opcodes resolve as not taken.
    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (ex_opcode)
            4'b0100: taken = $signed(ex_rd1) < $signed(ex_rd15);
            4'b0101: taken = $signed(ex_rd1) > $signed(ex_rd15);
            4'b0110: taken = (ex_rd1 == ex_rd15);
            4'b0111: taken = (ex_rd1 != ex_rd15);
            4'b1000: taken = (ex_rd1 < ex_rd15);
            4'b1001: taken = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

    // The shadow flag marks the wrong-path slot that follows a redirect.
    assign resolve     = ex_valid & ex_branch & ~shadow;
    assign mispredict  = taken != ex_pred_taken;
    assign fallthrough = ex_pc + PC_W'(PC_INC);

    // Registered resolution outputs, shadow flag and saturating counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcsrc       <= 1'b0;
            redirect    <= 1'b0;
            illegal_br  <= 1'b0;
            redirect_pc <= '0;
            shadow      <= 1'b0;
            br_cnt      <= '0;
            mis_cnt     <= '0;
        end else begin
            pcsrc      <= 1'b0;
            redirect   <= 1'b0;
            illegal_br <= 1'b0;
            shadow     <= 1'b0;
            if (resolve) begin
                pcsrc       <= taken;
                redirect    <= mispredict;
                illegal_br  <= illegal;
                shadow      <= mispredict;
                redirect_pc <= taken ? ex_target : fallthrough;
                if (br_cnt != '1) begin
                    br_cnt <= br_cnt + CNT_W'(1);
                end
                if (mispredict && (mis_cnt != '1)) begin
                    mis_cnt <= mis_cnt + CNT_W'(1);
                end
            end
        end
    end

    // BHT training: saturating 2-bit counters, untouched by illegal opcodes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (resolve && !illegal) begin
            if (taken) begin
                if (bht[ex_idx] != 2'b11) begin
                    bht[ex_idx] <= bht[ex_idx] + 2'd1;
                end
            end else begin
                if (bht[ex_idx] != 2'b00) begin
                    bht[ex_idx] <= bht[ex_idx] - 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit
//
// Drives directed scenarios and a randomized phase into branch_resolve_unit.
// A behavioural model (integer table, integer counters) predicts every
// output, and a negedge process compares the DUT against it each cycle.
// Directed scenarios also check hand-computed literal values. The counters
// are narrowed to 10 bits here so that saturation is reachable.

module tb_branch_resolve_unit;

    localparam int DATA_W    = 16;
    localparam int PC_W      = 16;
    localparam int BHT_DEPTH = 16;
    localparam int PC_INC    = 1;
    localparam int CNT_W     = 10;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [PC_W-1:0]   if_pc;
    logic              if_pred_taken;
    logic              ex_valid;
    logic              ex_branch;
    logic [3:0]        ex_opcode;
    logic [DATA_W-1:0] ex_rd1;
    logic [DATA_W-1:0] ex_rd15;
    logic [PC_W-1:0]   ex_pc;
    logic [PC_W-1:0]   ex_target;
    logic              ex_pred_taken;
    logic              pcsrc;
    logic              redirect;
    logic [PC_W-1:0]   redirect_pc;
    logic              illegal_br;
    logic [CNT_W-1:0]  br_cnt;
    logic [CNT_W-1:0]  mis_cnt;

    branch_resolve_unit #(
        .DATA_W(DATA_W), .PC_W(PC_W), .BHT_DEPTH(BHT_DEPTH),
        .PC_INC(PC_INC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_opcode(ex_opcode),
        .ex_rd1(ex_rd1), .ex_rd15(ex_rd15), .ex_pc(ex_pc), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .pcsrc(pcsrc), .redirect(redirect),
        .redirect_pc(redirect_pc), .illegal_br(illegal_br),
        .br_cnt(br_cnt), .mis_cnt(mis_cnt)
    );

    always #5 clk = ~clk;

    int testsRun = 0;
    int testsFailed = 0;
    bit checkEn = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: plain integers for the table and counters.
    int mBht [BHT_DEPTH];
    int mBr = 0;
    int mMis = 0;
    bit mShadow = 1'b0;
    bit ePcsrc = 1'b0;
    bit eRedirect = 1'b0;
    bit eIllegal = 1'b0;
    int eRpc = 0;
    bit mTaken;
    bit mBad;
    int mA;
    int mB;
    int mIdx;

    initial begin
        for (int i = 0; i < BHT_DEPTH; i++) mBht[i] = 1;
    end

    function automatic int toSigned(input logic [15:0] v);
        return v[15] ? int'(v) - 65536 : int'(v);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) mBht[i] = 1;
            mBr = 0; mMis = 0; mShadow = 0;
            ePcsrc = 0; eRedirect = 0; eIllegal = 0; eRpc = 0;
        end else if (ex_valid && ex_branch && !mShadow) begin
            mA = toSigned(ex_rd1);
            mB = toSigned(ex_rd15);
            mBad = 0;
            case (ex_opcode)
                4'd4:    mTaken = mA < mB;
                4'd5:    mTaken = mA > mB;
                4'd6:    mTaken = ex_rd1 == ex_rd15;
                4'd7:    mTaken = ex_rd1 != ex_rd15;
                4'd8:    mTaken = int'(ex_rd1) < int'(ex_rd15);
                4'd9:    mTaken = 1;
                default: begin mTaken = 0; mBad = 1; end
            endcase
            ePcsrc = mTaken;
            eRedirect = (mTaken != ex_pred_taken);
            eIllegal = mBad;
            eRpc = mTaken ? int'(ex_target) : (int'(ex_pc) + PC_INC) % 65536;
            if (mBr < CNT_MAX) mBr++;
            if (eRedirect && mMis < CNT_MAX) mMis++;
            mIdx = int'(ex_pc) % BHT_DEPTH;
            if (!mBad) begin
                if (mTaken && mBht[mIdx] < 3) mBht[mIdx]++;
                if (!mTaken && mBht[mIdx] > 0) mBht[mIdx]--;
            end
            mShadow = eRedirect;
        end else begin
            ePcsrc = 0; eRedirect = 0; eIllegal = 0; mShadow = 0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("cyc_pcsrc", pcsrc, ePcsrc);
            checkOutput("cyc_redirect", redirect, eRedirect);
            checkOutput("cyc_redirect_pc", redirect_pc, eRpc);
            checkOutput("cyc_illegal_br", illegal_br, eIllegal);
            checkOutput("cyc_br_cnt", br_cnt, mBr);
            checkOutput("cyc_mis_cnt", mis_cnt, mMis);
            checkOutput("cyc_if_pred", if_pred_taken, mBht[int'(if_pc) % BHT_DEPTH] >= 2);
        end
    end

    // Present one EX slot, then return 1 time unit after the sampling edge.
    task automatic applyStimulus(input bit v, input bit br, input logic [3:0] op,
                                 input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] pc, input logic [15:0] tgt, input bit pred);
        ex_valid = v; ex_branch = br; ex_opcode = op;
        ex_rd1 = a; ex_rd15 = b; ex_pc = pc; ex_target = tgt; ex_pred_taken = pred;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 4'd0, 16'd0, 16'd0, 16'd0, 16'd0, 0);
    endtask

    initial begin
        if_pc = 16'h0000;
        ex_valid = 0; ex_branch = 0; ex_opcode = 0; ex_rd1 = 0; ex_rd15 = 0;
        ex_pc = 0; ex_target = 0; ex_pred_taken = 0;
        repeat (2) @(posedge clk);
        #1;
        checkEn = 1;
        rst_n = 1;

        // Reset state
        checkOutput("rst_pcsrc", pcsrc, 0);
        checkOutput("rst_redirect", redirect, 0);
        checkOutput("rst_redirect_pc", redirect_pc, 0);
        checkOutput("rst_br_cnt", br_cnt, 0);
        checkOutput("rst_mis_cnt", mis_cnt, 0);
        checkOutput("rst_if_pred", if_pred_taken, 0);

        // Signed compare, mispredict
        applyStimulus(1, 1, 4'b0100, 16'd5, 16'd15, 16'h0010, 16'h0040, 0);
        checkOutput("blt_pcsrc", pcsrc, 1);
        checkOutput("blt_redirect", redirect, 1);
        checkOutput("blt_redirect_pc", redirect_pc, 16'h0040);
        checkOutput("blt_mis_cnt", mis_cnt, 1);
        checkOutput("blt_bht0", dut.bht[0], 2'b10);
        checkOutput("blt_if_pred", if_pred_taken, 1);

        // Shadow slot: taken branch ignored
        applyStimulus(1, 1, 4'b1001, 16'd0, 16'd0, 16'h0010, 16'h0040, 0);
        checkOutput("shadow_pcsrc", pcsrc, 0);
        checkOutput("shadow_br_cnt", br_cnt, 1);
        checkOutput("shadow_bht0", dut.bht[0], 2'b10);

        // BGT not taken
        applyStimulus(1, 1, 4'b0101, 16'd5, 16'd15, 16'h0010, 16'h0040, 0);
        checkOutput("bgt_pcsrc", pcsrc, 0);
        checkOutput("bgt_redirect", redirect, 0);
        checkOutput("bgt_redirect_pc", redirect_pc, 16'h0011);
        checkOutput("bgt_br_cnt", br_cnt, 2);

        // Signed vs unsigned
        applyStimulus(1, 1, 4'b0100, 16'hFFFF, 16'd1, 16'h0020, 16'h0050, 1);
        checkOutput("blt_neg_pcsrc", pcsrc, 1);
        checkOutput("blt_neg_redirect_pc", redirect_pc, 16'h0050);
        applyStimulus(1, 1, 4'b1000, 16'hFFFF, 16'd1, 16'h0020, 16'h0050, 0);
        checkOutput("bltu_pcsrc", pcsrc, 0);
        checkOutput("bltu_redirect_pc", redirect_pc, 16'h0021);
        checkOutput("bltu_br_cnt", br_cnt, 4);
        applyStimulus(1, 0, 4'b0100, 16'hFFFF, 16'd1, 16'h0020, 16'h0050, 0);
        checkOutput("nobr_pcsrc", pcsrc, 0);
        checkOutput("nobr_br_cnt", br_cnt, 4);
        applyStimulus(1, 0, 4'b1000, 16'hFFFF, 16'd1, 16'h0020, 16'h0050, 0);
        checkOutput("nobr_u_br_cnt", br_cnt, 4);
        checkOutput("nobr_redirect_pc", redirect_pc, 16'h0021);

        // BHT saturation with aliasing fetch PC
        if_pc = 16'h0013;
        repeat (4) applyStimulus(1, 1, 4'b1001, 16'd0, 16'd0, 16'h0003, 16'h0030, 1);
        checkOutput("sat_bht3", dut.bht[3], 2'b11);
        checkOutput("sat_if_pred", if_pred_taken, 1);
        checkOutput("sat_br_cnt", br_cnt, 8);
        applyStimulus(1, 1, 4'b0110, 16'd1, 16'd2, 16'h0003, 16'h0030, 1);
        checkOutput("sat_nt_bht3", dut.bht[3], 2'b10);
        checkOutput("sat_nt_if_pred", if_pred_taken, 1);
        checkOutput("sat_nt_redirect_pc", redirect_pc, 16'h0004);
        idle();

        // PC wrap on fall-through
        applyStimulus(1, 1, 4'b0111, 16'd7, 16'd7, 16'hFFFF, 16'h1234, 1);
        checkOutput("wrap_redirect", redirect, 1);
        checkOutput("wrap_redirect_pc", redirect_pc, 16'h0000);
        idle();

        // Illegal opcode
        applyStimulus(1, 1, 4'b1111, 16'd0, 16'd0, 16'h0000, 16'h0040, 0);
        checkOutput("ill_flag", illegal_br, 1);
        checkOutput("ill_pcsrc", pcsrc, 0);
        checkOutput("ill_bht0", dut.bht[0], 2'b01);
        checkOutput("ill_br_cnt", br_cnt, 11);
        idle();
        checkOutput("ill_clear", illegal_br, 0);

        // Randomized phase
        for (int n = 0; n < 1500; n++) begin
            logic [3:0] op;
            logic [15:0] a;
            logic [15:0] b;
            if_pc = 16'($urandom_range(0, 63));
            op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(4, 9));
            a = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            b = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            applyStimulus($urandom_range(0, 5) != 0, $urandom_range(0, 4) != 0, op, a, b,
                          16'($urandom_range(0, 40)) - 16'd4, 16'($urandom), $urandom_range(0, 1) == 1);
        end

        // Counter saturation
        for (int n = 0; n < 1100; n++) begin
            applyStimulus(1, 1, 4'b1001, 16'd0, 16'd0, 16'($urandom_range(0, 31)), 16'h0100, 1);
        end
        checkOutput("brcnt_saturated", br_cnt, CNT_MAX);
        applyStimulus(1, 1, 4'b1001, 16'd0, 16'd0, 16'h0005, 16'h0100, 1);
        checkOutput("brcnt_held", br_cnt, CNT_MAX);
        idle();

        // Asynchronous reset while redirect is high
        if_pc = 16'h0013;
        applyStimulus(1, 1, 4'b0100, 16'd5, 16'd15, 16'h0010, 16'h0040, 0);
        checkOutput("pre_rst_redirect", redirect, 1);
        #2;
        rst_n = 0;
        #1;
        checkOutput("arst_redirect", redirect, 0);
        checkOutput("arst_br_cnt", br_cnt, 0);
        checkOutput("arst_mis_cnt", mis_cnt, 0);
        checkOutput("arst_bht0", dut.bht[0], 2'b01);
        checkOutput("arst_bht3", dut.bht[3], 2'b01);
        checkOutput("arst_if_pred", if_pred_taken, 0);
        ex_valid = 0; ex_branch = 0;
        @(negedge clk);
        #1;
        rst_n = 1;
        @(posedge clk);
        #1;
        if_pc = 16'h0000;
        applyStimulus(1, 1, 4'b0100, 16'd5, 16'd15, 16'h0010, 16'h0040, 0);
        checkOutput("post_rst_pcsrc", pcsrc, 1);
        checkOutput("post_rst_redirect", redirect, 1);
        checkOutput("post_rst_redirect_pc", redirect_pc, 16'h0040);
        checkOutput("post_rst_mis_cnt", mis_cnt, 1);
        checkOutput("post_rst_br_cnt", br_cnt, 1);
        checkOutput("post_rst_bht0", dut.bht[0], 2'b10);
        idle();
        idle();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised, pipelined successor to the combinational branch-condition logic.
- Resolves conditional branches in EX by comparing a source register (rd1) against R15 (rd15).
- Holds a 2-bit saturating-counter branch history table (BHT) that provides IF-stage predictions.
- Registers the PC-source decision with one cycle of latency, raises a redirect on mispredict, squashes the wrong-path slot, and keeps saturating performance counters.

Parameters:
- DATA_W, 16: width of rd1/rd15 operands.
- PC_W, 16: width of PC and target.
- BHT_DEPTH, 16: number of BHT entries; must be a power of two; index = pc[log2(BHT_DEPTH)-1:0].
- PC_INC, 1: fall-through increment (word-addressed PC).
- CNT_W, 16: width of performance counters.

Ports:
- clk, in, 1: rising-edge clock.
- rst_n, in, 1: asynchronous active-low reset.
- if_pc, in, PC_W: fetch PC used for the prediction lookup.
- if_pred_taken, out, 1: combinational; MSB of BHT[if_pc index].
- ex_valid, in, 1: the EX slot holds a valid instruction.
- ex_branch, in, 1: the EX instruction is a branch (the old "branch" input).
- ex_opcode, in, 4: branch condition select.
- ex_rd1, in, DATA_W: first operand.
- ex_rd15, in, DATA_W: R15 operand.
- ex_pc, in, PC_W: PC of the EX instruction.
- ex_target, in, PC_W: branch target.
- ex_pred_taken, in, 1: prediction made at fetch time and carried down the pipe.
- pcsrc, out, 1: registered; the resolved branch was taken.
- redirect, out, 1: registered; mispredict, so fetch must restart at redirect_pc.
- redirect_pc, out, PC_W: registered; correct next PC.
- illegal_br, out, 1: registered; ex_branch was set with an undefined opcode.
- br_cnt, out, CNT_W: resolved branches, saturating.
- mis_cnt, out, CNT_W: mispredicts, saturating.

Behaviour:
- Reset (async, rst_n=0):
  - pcsrc, redirect, illegal_br, redirect_pc, br_cnt and mis_cnt all clear to 0.
  - Every BHT entry resets to 2'b01 (weakly not-taken).
  - The shadow flag clears.
- Conditions, evaluated on ex_opcode:
  - 0100 BLT: signed rd1 < rd15.
  - 0101 BGT: signed rd1 > rd15.
  - 0110 BEQ: rd1 == rd15.
  - 0111 BNE: rd1 != rd15.
  - 1000 BLTU: unsigned rd1 < rd15.
  - 1001 JMP: always taken.
  - Any other opcode: not taken, and illegal_br=1 for one cycle.
- Resolve event: ex_valid & ex_branch & !shadow at a rising edge.
- Next cycle after a resolve event:
  - pcsrc = taken.
  - redirect = (taken != ex_pred_taken).
  - redirect_pc = taken ? ex_target : ex_pc + PC_INC, computed modulo 2^PC_W (wraps).
- If no resolve event occurs in a cycle, pcsrc, redirect and illegal_br are 0 on the next cycle. redirect_pc holds its last value.
- Latency: exactly 1 cycle from the sampling edge to the outputs.
- Shadow:
  - The shadow flag is set in the same cycle redirect=1.
  - While the flag is set, the EX slot is wrong-path. Nothing resolves: no outputs, no BHT update, no counter change.
  - The flag clears on the following edge.
  - Back-to-back redirects are therefore impossible.
- BHT update on a resolve event, at the same edge, for entry ex_pc index:
  - Taken: increment, saturating at 2'b11.
  - Not taken: decrement, saturating at 2'b00.
  - Illegal opcode: no update.
- Prediction read vs. update:
  - if_pred_taken is a combinational read of the current table (no bypass).
  - When if_pc and ex_pc hit the same index in the same cycle, the prediction sees the pre-update value.
- Counters on a resolve event:
  - br_cnt increments, including on illegal opcodes.
  - mis_cnt increments when redirect will be asserted.
  - Both saturate at 2^CNT_W-1 and do not wrap.
- ex_branch=0 or ex_valid=0: no effect.
- Reset asserted mid-operation clears state immediately, independent of clk. Pending results are discarded.

Test Plan:
- Signed compare: reset; rd1=5, rd15=15, branch=1, opcode=0100, pred=0, pc=0x0010, target=0x0040 -> next cycle pcsrc=1, redirect=1, redirect_pc=0x0040, mis_cnt=1, BHT[0]=2'b10. Repeat with opcode=0101 -> pcsrc=0, redirect=0.
- Signed vs. unsigned: rd1=16'hFFFF, rd15=1; opcode 0100 -> taken; opcode 1000 -> not taken. branch=0 with either opcode -> pcsrc=0, br_cnt unchanged.
- Shadow: a mispredict at cycle N gives redirect=1 at N+1. A valid taken branch presented at N+1 is ignored: no BHT change, br_cnt unchanged, pcsrc=0 at N+2.
- BHT saturation: four taken resolves at pc=0x0003 -> entry 2'b11 and if_pred_taken=1 for if_pc=0x0013 (aliases to index 3). One not-taken resolve -> 2'b10, prediction still 1.
- Edge cases:
  - ex_pc=16'hFFFF not taken with pred=1 -> redirect_pc=0x0000.
  - opcode=1111 with branch=1 -> illegal_br=1, pcsrc=0, BHT unchanged.
  - Force br_cnt to 16'hFFFF; a further branch -> br_cnt stays 16'hFFFF.
- Async reset: drop rst_n between clock edges while redirect=1 -> redirect, counters and BHT clear immediately. The first resolve after release behaves as in the signed-compare scenario.
